// File: rtl/irq_controller.sv
// Prioritised interrupt/exception controller: masks, edge/level pending, PC redirect handshake.
// Optional build macro IRQ_EDGE_EN adds the EDGE register, edge detectors and PENDING W1C.
module irq_controller #(
  parameter int unsigned N_SRC   = 4,
  parameter logic [31:0] IRQ_VEC = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC = 32'h8000_0008
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic             exc_src_i,
  input  logic             kernel_mode_i,
  input  logic             ack_i,
  input  logic             eret_i,
  input  logic             cfg_wr_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             redirect_o,
  output logic [31:0]      vector_o,
  output logic [5:0]       cause_o,
  output logic             in_service_o
);

  // state   | meaning
  // IDLE    | waiting for an eligible request outside kernel mode
  // REQ     | redirect raised, vector/cause held until ack
  // SERVICE | handler running, waiting for eret
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

  // Internal vectors are 32 bits wide; bits above N_SRC are tied to zero.
  localparam logic [31:0] IMPL = (N_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_SRC) - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] vec_q, vec_d;
  logic [5:0]  cause_q, cause_d;
  logic [31:0] src32, pending32, req_vec, edge_rd;
  logic [4:0]  req_id;
  logic        wr_mask;

  assign src32   = 32'(irq_src_i);
  assign wr_mask = cfg_wr_i && (cfg_addr_i == 2'd0);

`ifdef IRQ_EDGE_EN
  logic [31:0] edge_q, edge_d, pend_q, pend_d, prev_q;
  logic [31:0] rise, w1c, ack_clr;
  logic        wr_edge, wr_pend;

  assign wr_edge   = cfg_wr_i && (cfg_addr_i == 2'd1);
  assign wr_pend   = cfg_wr_i && (cfg_addr_i == 2'd2);
  assign rise      = src32 & ~prev_q;
  assign w1c       = wr_pend ? cfg_wdata_i : 32'd0;
  assign pending32 = (pend_q & edge_q) | (src32 & ~edge_q);
  assign edge_rd   = edge_q;

  always_comb begin
    edge_d  = wr_edge ? (cfg_wdata_i & IMPL) : edge_q;
    ack_clr = '0;
    if (state_q == S_REQ && ack_i && !cause_q[5]) ack_clr[cause_q[4:0]] = 1'b1;
    // A new edge wins over a same-cycle W1C or ack clear.
    pend_d  = ((pend_q & ~ack_clr & ~w1c) | rise) & edge_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      edge_q <= edge_d;
      pend_q <= pend_d;
      prev_q <= src32;
    end
  end
`else
  assign pending32 = src32;
  assign edge_rd   = '0;
`endif

  assign req_vec = pending32 & mask_q;

  always_comb begin
    req_id = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req_vec[i]) req_id = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cause_d = cause_q;
    mask_d  = wr_mask ? (cfg_wdata_i & IMPL) : mask_q;
    case (state_q)
      S_IDLE: begin
        if ((exc_src_i || (|req_vec)) && !kernel_mode_i) begin
          state_d = S_REQ;
          if (exc_src_i) begin
            cause_d = 6'h20;
            vec_d   = EXC_VEC;
          end else begin
            cause_d = {1'b0, req_id};
            vec_d   = IRQ_VEC;
          end
        end
      end
      S_REQ:     if (ack_i)  state_d = S_SERVICE;
      S_SERVICE: if (eret_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      vec_q   <= IRQ_VEC;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    case (cfg_addr_i)
      2'd0:    cfg_rdata_o = mask_q;
      2'd1:    cfg_rdata_o = edge_rd;
      2'd2:    cfg_rdata_o = pending32;
      default: cfg_rdata_o = {26'd0, cause_q};
    endcase
  end

  assign redirect_o   = (state_q == S_REQ);
  assign in_service_o = (state_q == S_SERVICE);
  assign vector_o     = vec_q;
  assign cause_o      = cause_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expected redirects queued by stimulus, popped by a monitor.
module tb_irq_controller;
  localparam int          N       = 4;
  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  irq_src_i;
  logic          exc_src_i, kernel_mode_i, ack_i, eret_i, cfg_wr_i;
  logic [1:0]    cfg_addr_i;
  logic [31:0]   cfg_wdata_i, cfg_rdata_o, vector_o;
  logic          redirect_o, in_service_o;
  logic [5:0]    cause_o;

  int errors = 0;
  int checks = 0;
  logic [37:0] exp_q[$];
  logic [37:0] exp_e;
  logic        prev_red = 1'b0;

  irq_controller #(.N_SRC(N), .IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_src_i(irq_src_i), .exc_src_i(exc_src_i),
    .kernel_mode_i(kernel_mode_i), .ack_i(ack_i), .eret_i(eret_i), .cfg_wr_i(cfg_wr_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .redirect_o(redirect_o), .vector_o(vector_o), .cause_o(cause_o), .in_service_o(in_service_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new redirect must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (redirect_o && !prev_red) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: redirect vector %h cause %h with nothing queued", vector_o, cause_o);
      end else begin
        exp_e = exp_q.pop_front();
        chk("sb_vector", vector_o, exp_e[37:6]);
        chk("sb_cause", {26'd0, cause_o}, {26'd0, exp_e[5:0]});
      end
    end
    prev_red = redirect_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_wr_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    tick();
    cfg_wr_i = 1'b0; cfg_wdata_i = '0;
  endtask

  task automatic wait_red(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (redirect_o) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: redirect got 0 expected 1 within 8 cycles", name);
    end
  endtask

  task automatic serve();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0; kernel_mode_i = 1'b1;
  endtask

  task automatic retire();
    eret_i = 1'b1; kernel_mode_i = 1'b0;
    tick();
    eret_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_ni = 1'b0; irq_src_i = '0; exc_src_i = 0; kernel_mode_i = 0;
    ack_i = 0; eret_i = 0; cfg_wr_i = 0; cfg_addr_i = 2'd0; cfg_wdata_i = '0;
    repeat (3) tick();

    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_vector", vector_o, IRQ_VEC);
    chk("rst_cause", {26'd0, cause_o}, 32'd0);
    chk("rst_in_service", {31'd0, in_service_o}, 32'd0);
    chk("rst_rdata", cfg_rdata_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    cfg_write(2'd0, 32'hFFFF_FFFF);
    cfg_addr_i = 2'd0; #1;
    chk("mask_rb", cfg_rdata_o, 32'h0000_000F);
    cfg_addr_i = 2'd3; #1;
    chk("cause_rb_idle", cfg_rdata_o, 32'd0);

    // Level source 2: redirect one edge after the line rises.
    exp_q.push_back({IRQ_VEC, 6'h02});
    irq_src_i = 4'b0100;
    @(posedge clk_i); @(negedge clk_i);
    chk("lvl_latency", {31'd0, redirect_o}, 32'd1);
    serve();
    irq_src_i = '0;
    chk("lvl_ack_redirect", {31'd0, redirect_o}, 32'd0);
    chk("lvl_ack_in_service", {31'd0, in_service_o}, 32'd1);
    retire();
    chk("lvl_eret_in_service", {31'd0, in_service_o}, 32'd0);
    tick();
    chk("lvl_no_rereq", {31'd0, redirect_o}, 32'd0);

    // Exception beats interrupts; interrupt 0 follows after eret.
    exp_q.push_back({EXC_VEC, 6'h20});
    exp_q.push_back({IRQ_VEC, 6'h00});
    exc_src_i = 1'b1; irq_src_i = 4'b0011;
    wait_red("prio_exc_wait");
    serve();
    exc_src_i = 1'b0;
    chk("prio_in_service", {31'd0, in_service_o}, 32'd1);
    retire();
    wait_red("prio_irq_wait");
    cfg_addr_i = 2'd3; #1;
    chk("prio_cause_rb", cfg_rdata_o, 32'd0);
    serve();
    irq_src_i = '0;
    retire();

    // Masking the selected source while in REQ does not withdraw it.
    exp_q.push_back({IRQ_VEC, 6'h03});
    irq_src_i = 4'b1000;
    wait_red("hold_wait");
    cfg_write(2'd0, 32'h0);
    chk("hold_redirect", {31'd0, redirect_o}, 32'd1);
    chk("hold_cause", {26'd0, cause_o}, 32'h03);
    chk("hold_vector", vector_o, IRQ_VEC);
    serve();
    irq_src_i = '0;
    retire();
    cfg_write(2'd0, 32'hF);

`ifdef IRQ_EDGE_EN
    cfg_write(2'd1, 32'h2);
    cfg_addr_i = 2'd1; #1;
    chk("edge_rb", cfg_rdata_o, 32'h2);
    exp_q.push_back({IRQ_VEC, 6'h02});
    irq_src_i = 4'b0100;
    wait_red("edge_pre_wait");
    serve();
    irq_src_i = 4'b0010;
    tick();
    irq_src_i = 4'b0000;
    tick();
    cfg_addr_i = 2'd2; #1;
    chk("edge_pending", cfg_rdata_o, 32'h2);
    exp_q.push_back({IRQ_VEC, 6'h01});
    retire();
    wait_red("edge_req_wait");
    serve();
    cfg_addr_i = 2'd2; #1;
    chk("edge_ack_clear", cfg_rdata_o, 32'h0);
    retire();

    kernel_mode_i = 1'b1;
    cfg_wr_i = 1'b1; cfg_addr_i = 2'd2; cfg_wdata_i = 32'h2; irq_src_i = 4'b0010;
    tick();
    cfg_wr_i = 1'b0;
    chk("w1c_collision", cfg_rdata_o, 32'h2);
    cfg_write(2'd2, 32'h2);
    chk("w1c_clear", cfg_rdata_o, 32'h0);
    irq_src_i = '0; kernel_mode_i = 1'b0;
    cfg_write(2'd1, 32'h0);
`else
    cfg_write(2'd1, 32'h2);
    cfg_addr_i = 2'd1; #1;
    chk("edge_ignored", cfg_rdata_o, 32'h0);
    kernel_mode_i = 1'b1;
    irq_src_i = 4'b0101;
    cfg_addr_i = 2'd2; #1;
    chk("pend_mirror", cfg_rdata_o, 32'h5);
    cfg_write(2'd2, 32'h5);
    chk("pend_wr_ignored", cfg_rdata_o, 32'h5);
    irq_src_i = '0; kernel_mode_i = 1'b0;
    tick();
`endif

    // Kernel mode blocks requests; reset in REQ clears everything at once.
    kernel_mode_i = 1'b1; irq_src_i = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (redirect_o) seen = 1'b1;
    end
    chk("kernel_block", {31'd0, seen}, 32'd0);
    exp_q.push_back({IRQ_VEC, 6'h00});
    kernel_mode_i = 1'b0;
    wait_red("kernel_release_wait");
    #2;
    rst_ni = 1'b0;
    #1;
    cfg_addr_i = 2'd0; #1;
    chk("arst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("arst_in_service", {31'd0, in_service_o}, 32'd0);
    chk("arst_cause", {26'd0, cause_o}, 32'd0);
    chk("arst_mask", cfg_rdata_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("post_rst_masked", {31'd0, redirect_o}, 32'd0);
    irq_src_i = '0;
    tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt/exception controller for the pipelined MIPS core, replacing the fixed two-source `timer || uart_send` and hard-wired exception logic. It accepts N_SRC interrupt lines plus one exception line, applies masking and per-line edge/level selection, picks the highest-priority request and holds a registered redirect request toward the PC until the core acknowledges it. It then tracks handler service until return and exposes mask, edge, pending and cause state through a small memory-mapped register port on the peripheral bus.

## Interface
- N_SRC, 4, number of interrupt sources (1..32); index 0 is highest priority
- IRQ_VEC, 32'h80000004, handler address for interrupts
- EXC_VEC, 32'h80000008, handler address for exceptions
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- irq_src  in  N_SRC  raw interrupt lines, synchronous to clk
- exc_src  in  1  exception request (core hazard, PC overflow), level
- kernel_mode  in  1  PC_IF[31]; 1 = executing in kernel space
- ack  in  1  core loaded the vector into PC this cycle
- eret  in  1  handler returned (PC leaves kernel space)
- cfg_wr  in  1  register write strobe
- cfg_addr  in  2  register select: 0 MASK, 1 EDGE, 2 PENDING, 3 CAUSE
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational from cfg_addr
- redirect  out  1  request to the PC mux to take `vector`
- vector  out  32  target address, valid while redirect=1
- cause  out  6  {is_exception, id[4:0]} of the request being or last serviced
- in_service  out  1  handler active

## Operation
- MASK: bit i=1 enables source i. EDGE: bit i=1 means rising-edge sensitive, 0 means level. Both are R/W and only bits [N_SRC-1:0] are implemented; upper bits read 0.
- PENDING: bit i is set on a detected rising edge (edge mode) or tracks irq_src[i] directly (level mode). Writing 1 clears an edge-mode bit. Writes to level bits are ignored. Pending is captured regardless of MASK.
- CAUSE: read-only; returns {26'd0, cause}.
- Eligible request: (pending & mask) nonzero or exc_src=1. The selected id is the lowest set index. An exception beats every interrupt.
- FSM states:
  - IDLE: if an eligible request is present and kernel_mode=0 and in_service=0, go to REQ. Latch cause. Set vector to EXC_VEC for an exception, IRQ_VEC otherwise.
  - REQ: redirect=1 and vector/cause are held stable. On ack, go to SERVICE and clear the pending bit of the selected edge-mode id. ack=0 keeps the FSM in REQ.
  - SERVICE: in_service=1 and redirect=0. New requests accumulate in PENDING. On eret, go to IDLE.
- While kernel_mode=1, requests are never raised (no nesting). exc_src during kernel_mode is dropped, with no sticky record.
- Each cfg write touches at most one register per cycle.

## Timing
- Reset values: redirect=0, vector=IRQ_VEC, cause=0, in_service=0, cfg_rdata=MASK value=0. Also MASK=0, EDGE=0, PENDING=0, FSM=IDLE. Edge-detect history is reset to 0, so a line that is already high at reset release counts as an edge.
- Edge detect: a rising edge of irq_src at cycle n sets PENDING at the n+1 edge. redirect rises at the n+2 edge, if IDLE and eligible.
- Level/exception input high at cycle n gives redirect at the n+1 edge.
- redirect is registered and deasserts on the edge where ack is sampled high. in_service rises on that same edge.
- eret sampled high leaves SERVICE on that edge. A still-eligible request re-raises redirect one cycle later, at the earliest.
- ack while in IDLE or SERVICE, and eret while in IDLE or REQ, are ignored.
- A W1C to a pending bit in the same cycle as a new edge on that bit leaves it set.
- A MASK write that disables the selected source while in REQ does not withdraw the request; cause and vector stay latched until ack.
- Asserting reset mid-operation clears all state immediately, asynchronously.

## Configuration
- `IRQ_EDGE_EN` defined: EDGE register, edge detectors and PENDING W1C are implemented as described.
- Not defined: all sources are level-sensitive, EDGE reads 0 and ignores writes, PENDING mirrors irq_src, and PENDING writes are ignored.

## Test plan
- Reset release, N_SRC=4: all outputs at reset values. Write MASK=4'hF, read back 32'h0000000F.
- Level: irq_src=4'b0100 with kernel_mode=0 -> redirect=1, vector=32'h80000004, cause=6'h02 one cycle later. ack -> redirect=0, in_service=1. eret -> in_service=0.
- Priority: exc_src=1 together with irq_src=4'b0011 -> vector=32'h80000008, cause=6'h20. After eret, the interrupt is served next with cause=6'h00.
- Edge (`IRQ_EDGE_EN`): EDGE=4'h2, pulse irq_src[1] for one cycle while in SERVICE -> PENDING reads 4'h2. After eret, redirect with cause=6'h01. ack -> PENDING=0.
- W1C collision: write PENDING=4'h2 in the same cycle as a new rising edge on bit 1 -> PENDING stays 4'h2.
- Kernel blocking and reset: kernel_mode=1 with irq_src=4'h1 gives no redirect for 20 cycles. Assert reset while in REQ -> redirect=0 and FSM=IDLE immediately.
